// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream master among NUM_REQ requesters.
// Grants are held until end of packet, burst limit or the granted requester goes idle;
// beats are forwarded through a one-deep registered output stage tagged with m_id.
module stream_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      m_valid,
  output logic [DATA_W-1:0]         m_s_data,
  output logic                      m_last,
  output logic [ID_W-1:0]           m_id,
  input  logic                      s_ready,
  output logic                      busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [ID_W-1:0]   m_id_q, m_id_d;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W:0]     sum;
  logic [ID_W-1:0]   gnt_inc;
  logic              gnt_valid;
  logic              gnt_last;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_ready;
  logic              accept;

  // First valid requester searching upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[ID_W-1:0];
      end
    end
  end

  // Select the granted requester's beat.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == gnt_q) begin
        gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign gnt_valid = req_valid[gnt_q];
  assign gnt_last  = req_last[gnt_q];
  assign gnt_inc   = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  // Ready never depends on req_valid; it is suppressed while reset is asserted.
  assign gnt_ready = (state_q == StGrant) && !nrst && (!m_valid_q || s_ready);
  assign req_ready = gnt_ready ? (NUM_REQ'(1) << gnt_q) : '0;
  assign accept    = gnt_ready && gnt_valid;

  // Next-state logic for the arbitration FSM and the output stage.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_id_d     = m_id_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d      = winner;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (!gnt_valid) begin
          // Granted requester went idle: release without accepting.
          state_d = StIdle;
          ptr_d   = gnt_inc;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (gnt_last || (beat_cnt_d == 8'(BURST_MAX))) begin
            state_d = StIdle;
            ptr_d   = gnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new beat replaces a draining one with no bubble.
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = gnt_data;
      m_last_d  = gnt_last;
      m_id_d    = gnt_q;
    end else if (m_valid_q && s_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output-stage registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_id_q     <= m_id_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_s_data = m_data_q;
  assign m_last   = m_last_q;
  assign m_id     = m_id_q;
  assign busy     = (state_q == StGrant);

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: per-requester beat queues feed the DUT, a
// packet-level round-robin model predicts the output beat order, and a monitor
// process compares every transferred beat and the output-stage handshake rules.
module tb_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            nrst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            m_valid, m_last, s_ready, busy;
  logic [DW-1:0]   m_s_data;
  logic [IW-1:0]   m_id;

  stream_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM), .ID_W(IW)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .m_valid  (m_valid),
    .m_s_data (m_s_data),
    .m_last   (m_last),
    .m_id     (m_id),
    .s_ready  (s_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] data; logic last;} beat_t;
  typedef struct packed {logic [7:0] data; logic last; logic [1:0] id;} exp_t;

  beat_t dq[N][$];  // beats still to be offered by each requester
  beat_t mq[N][$];  // same beats, consumed by the reference model
  exp_t  sb[$];     // expected output beats in order
  int    ptr_m;
  bit    rand_ready;
  int    n_cmp, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (dq[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = dq[i][0].data;
        req_last[i]            = dq[i][0].last;
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
    s_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic add(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    dq[r].push_back(b);
    mq[r].push_back(b);
  endtask

  // Packet-level round robin: pick first non-empty requester from ptr, take beats
  // until last, BURST_MAX beats, or the requester runs dry; then ptr = winner + 1.
  task automatic model();
    int    w, cnt;
    bit    any, stop;
    beat_t b;
    exp_t  e;
    forever begin
      any = 0;
      w   = 0;
      for (int k = 0; k < N; k++) begin
        if (!any && mq[(ptr_m + k) % N].size() > 0) begin
          any = 1;
          w   = (ptr_m + k) % N;
        end
      end
      if (!any) break;
      cnt  = 0;
      stop = 0;
      while (!stop) begin
        b      = mq[w].pop_front();
        e.data = b.data;
        e.last = b.last;
        e.id   = 2'(w);
        sb.push_back(e);
        cnt++;
        stop = b.last || (cnt == BM) || (mq[w].size() == 0);
      end
      ptr_m = (w + 1) % N;
    end
  endtask

  // One clock: capture handshakes before the edge, then update the sources after it.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(dq[i].pop_front());
    end
    drive_inputs();
  endtask

  function automatic bit sources_empty();
    bit e = 1;
    for (int i = 0; i < N; i++) if (dq[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic run_batch(input string name);
    bit done = 0;
    model();
    drive_inputs();
    for (int c = 0; c < 600 && !done; c++) begin
      step();
      done = (sb.size() == 0) && sources_empty() && !busy && !m_valid;
    end
    chk({"batch_done_", name}, {31'd0, done}, 32'd1);
    if (!done) begin
      sb.delete();
      for (int i = 0; i < N; i++) dq[i].delete();
    end
  endtask

  // Monitor: compare transferred beats with the scoreboard and check hold rules.
  bit            held;
  logic [7:0]    pd;
  logic          pl;
  logic [IW-1:0] pid;
  initial begin
    held = 0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
        held = 0;
      end else begin
        chk("ready_onehot", {31'd0, ($countones(req_ready) <= 1)}, 32'd1);
        if (req_ready != 0) chk("busy_when_ready", {31'd0, busy}, 32'd1);
        if (held) begin
          chk("hold_valid", {31'd0, m_valid}, 32'd1);
          chk("hold_data", {24'd0, m_s_data}, {24'd0, pd});
          chk("hold_last", {31'd0, m_last}, {31'd0, pl});
          chk("hold_id", {30'd0, m_id}, {30'd0, pid});
        end
        if (m_valid && !s_ready) chk("ready_while_held", {28'd0, req_ready}, 32'd0);
        if (m_valid && s_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got id %0d data %0h, expected none", m_id, m_s_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("beat_data", {24'd0, m_s_data}, {24'd0, e.data});
            chk("beat_last", {31'd0, m_last}, {31'd0, e.last});
            chk("beat_id", {30'd0, m_id}, {30'd0, e.id});
          end
        end
        held = m_valid && !s_ready;
        pd   = m_s_data;
        pl   = m_last;
        pid  = m_id;
      end
    end
  end

  initial begin
    bit seen;
    n_cmp      = 0;
    n_err      = 0;
    ptr_m      = 0;
    rand_ready = 0;
    nrst       = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    s_ready    = 1'b1;

    // Reset with every requester valid; then two single-beat packets each.
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++) add(r, 8'(8'h10 * r + p), 1'b1);
    drive_inputs();
    repeat (2) begin
      @(negedge clk);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_m_data", {24'd0, m_s_data}, 32'd0);
      chk("rst_m_id", {30'd0, m_id}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    nrst = 1'b0;
    run_batch("round_robin");

    // Burst limit interleaves requester 2 between requester 0's beats.
    for (int k = 0; k < 6; k++) add(0, 8'(8'hB0 + k), 1'b0);
    add(2, 8'hC0, 1'b1);
    run_batch("burst_limit");

    // Single packet from requester 1; leaves ptr at 2.
    add(1, 8'hA0, 1'b0);
    add(1, 8'hA1, 1'b0);
    add(1, 8'hA2, 1'b1);
    run_batch("single_packet");
    chk("busy_after_packet", {31'd0, busy}, 32'd0);

    // Reset pulse during beat 2 of requester 3.
    for (int k = 0; k < 4; k++) add(3, 8'(8'hD0 + k), 1'b0);
    model();
    drive_inputs();
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      seen = m_valid;
    end
    chk("midpkt_started", {31'd0, seen}, 32'd1);
    nrst = 1'b1;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      mq[i].delete();
    end
    drive_inputs();
    step();
    nrst  = 1'b0;
    ptr_m = 0;
    @(negedge clk);
    chk("midpkt_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midpkt_busy", {31'd0, busy}, 32'd0);
    // From ptr 0 requester 1 must win before requester 3.
    add(3, 8'hE3, 1'b1);
    add(1, 8'hE1, 1'b1);
    run_batch("after_reset");

    // Randomized traffic with random downstream backpressure.
    rand_ready = 1;
    for (int b = 0; b < 25; b++) begin
      for (int r = 0; r < N; r++) begin
        int n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++) add(r, 8'($urandom), ($urandom_range(0, 3) == 0));
      end
      run_batch("random");
    end
    rand_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
